// File: rtl/brush_writer.sv
`default_nettype none
// ============================================================================
// Module   : brush_writer
// Purpose  : Write-side controller for the canvas pixel store. It takes a
//            paint request (top-left corner, brush edge-1, colour) and walks
//            the square footprint row-major, presenting one store write per
//            clock. Pixels that fall off the canvas still take a cycle but
//            are not written. With BRUSH_CLEAR_EN defined, a clear request
//            sweeps the whole canvas to colour 0. The clear request has
//            priority over a paint request.
// Ports    : clk        - single clock
//            reset_n    - asynchronous active-low reset
//            req        - paint request, sampled only when idle
//            cx, cy     - brush top-left corner
//            size       - brush edge length minus 1 (edge 1..4)
//            color      - paint colour
//            clear_req  - canvas clear request, sampled only when idle
//                         (ignored unless BRUSH_CLEAR_EN is defined)
//            busy       - operation in progress
//            done       - one-cycle pulse after the last write
//            brush      - store write enable
//            wx, wy     - store write address
//            newColor   - store write data
// Macro    : BRUSH_CLEAR_EN enables the CLEAR state and the clear_req input
// Revision : 1.0 - initial release
// ============================================================================
module brush_writer #(
  parameter int COORD_W  = 10,
  parameter int COLOR_W  = 3,
  parameter int CANVAS_W = 16,
  parameter int CANVAS_H = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [1:0]         size,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear_req,
  output logic               busy,
  output logic               done,
  output logic               brush,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic [COLOR_W-1:0] newColor
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAINT = 2'd1
`ifdef BRUSH_CLEAR_EN
    , S_CLEAR = 2'd2
`endif
  } state_t;

  // Canvas limits extended by one bit so a carry out of the address sum
  // compares as out of range.
  localparam logic [COORD_W:0] c_lim_x = (COORD_W+1)'(CANVAS_W);
  localparam logic [COORD_W:0] c_lim_y = (COORD_W+1)'(CANVAS_H);

`ifdef BRUSH_CLEAR_EN
  localparam logic [COORD_W-1:0] c_x_last = COORD_W'(CANVAS_W - 1);
  localparam logic [COORD_W-1:0] c_y_last = COORD_W'(CANVAS_H - 1);
  localparam logic [COORD_W-1:0] c_one    = COORD_W'(1);
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_req;
`endif

  state_t             r_state;
  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic [1:0]         r_size;
  logic [1:0]         r_dx;   // offset of the pixel currently presented
  logic [1:0]         r_dy;

  logic [1:0]         w_dx_nxt;
  logic [1:0]         w_dy_nxt;
  logic               w_last;
  logic [COORD_W-1:0] w_bx;
  logic [COORD_W-1:0] w_by;
  logic [1:0]         w_ox;
  logic [1:0]         w_oy;
  logic [COORD_W:0]   w_sx;
  logic [COORD_W:0]   w_sy;
  logic               w_in;

  // Address of the pixel to present next. In IDLE this is the corner taken
  // straight from the request inputs, so the first write appears in the
  // cycle right after acceptance.
  always_comb begin
    w_last = (r_dx == r_size) && (r_dy == r_size);
    if (r_dx == r_size) begin
      w_dx_nxt = 2'd0;
      w_dy_nxt = r_dy + 2'd1;
    end else begin
      w_dx_nxt = r_dx + 2'd1;
      w_dy_nxt = r_dy;
    end
    if (r_state == S_IDLE) begin
      w_bx = cx;
      w_by = cy;
      w_ox = 2'd0;
      w_oy = 2'd0;
    end else begin
      w_bx = r_cx;
      w_by = r_cy;
      w_ox = w_dx_nxt;
      w_oy = w_dy_nxt;
    end
    w_sx = {1'b0, w_bx} + {{(COORD_W-1){1'b0}}, w_ox};
    w_sy = {1'b0, w_by} + {{(COORD_W-1){1'b0}}, w_oy};
    w_in = (w_sx < c_lim_x) && (w_sy < c_lim_y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_size   <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      brush    <= 1'b0;
      wx       <= '0;
      wy       <= '0;
      newColor <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          brush <= 1'b0;
`ifdef BRUSH_CLEAR_EN
          if (clear_req) begin
            r_state  <= S_CLEAR;
            busy     <= 1'b1;
            brush    <= 1'b1;
            wx       <= '0;
            wy       <= '0;
            newColor <= '0;
          end else
`endif
          if (req) begin
            r_state  <= S_PAINT;
            r_cx     <= cx;
            r_cy     <= cy;
            r_size   <= size;
            r_dx     <= 2'd0;
            r_dy     <= 2'd0;
            busy     <= 1'b1;
            brush    <= w_in;
            wx       <= w_sx[COORD_W-1:0];
            wy       <= w_sy[COORD_W-1:0];
            newColor <= color;
          end
        end

        S_PAINT: begin
          if (w_last) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            brush   <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_dx  <= w_dx_nxt;
            r_dy  <= w_dy_nxt;
            brush <= w_in;
            wx    <= w_sx[COORD_W-1:0];
            wy    <= w_sy[COORD_W-1:0];
          end
        end

`ifdef BRUSH_CLEAR_EN
        // The write address registers double as the sweep counters.
        S_CLEAR: begin
          if ((wx == c_x_last) && (wy == c_y_last)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            brush   <= 1'b0;
            done    <= 1'b1;
          end else if (wx == c_x_last) begin
            wx <= '0;
            wy <= wy + c_one;
          end else begin
            wx <= wx + c_one;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          brush   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_brush_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_brush_writer
// Purpose  : Directed self-checking bench for brush_writer: reset, single
//            pixel, full brush, edge clipping, ignored mid-paint request,
//            mid-operation reset and (with BRUSH_CLEAR_EN) canvas clear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brush_writer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req;
  logic [9:0] cx;
  logic [9:0] cy;
  logic [1:0] size;
  logic [2:0] color;
  logic       clear_req;
  logic       busy;
  logic       done;
  logic       brush;
  logic [9:0] wx;
  logic [9:0] wy;
  logic [2:0] newColor;

  int total = 0;
  int bad   = 0;

  brush_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .cx        (cx),
    .cy        (cy),
    .size      (size),
    .color     (color),
    .clear_req (clear_req),
    .busy      (busy),
    .done      (done),
    .brush     (brush),
    .wx        (wx),
    .wy        (wy),
    .newColor  (newColor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic b, input int x, input int y, input int c);
    chk({tag, "_brush"}, 32'(brush), 32'(b));
    chk({tag, "_wx"}, 32'(wx), x);
    chk({tag, "_wy"}, 32'(wy), y);
    chk({tag, "_color"}, 32'(newColor), c);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Accepts a paint request on the next edge, then checks each footprint
  // pixel in row-major order, the done cycle and the quiet cycle after it.
  // With mid set, a conflicting request and new inputs are presented while
  // the paint runs; they must change nothing.
  task automatic paint(input int px, input int py, input int sz, input int col,
                       input bit mid, input string tag);
    int k;
    int x;
    int y;
    @(negedge clk);
    req = 1'b1; cx = 10'(px); cy = 10'(py); size = 2'(sz); color = 3'(col);
    for (int dy = 0; dy <= sz; dy++) begin
      for (int dx = 0; dx <= sz; dx++) begin
        @(negedge clk);
        k = dy * (sz + 1) + dx;
        if (k == 0) req = 1'b0;
        if (mid && k == 2) begin
          req = 1'b1; cx = 10'd0; cy = 10'd0; size = 2'd0; color = 3'd7;
        end
        if (mid && k == 5) req = 1'b0;
        x = px + dx;
        y = py + dy;
        chk_px(tag, (x < 16) && (y < 16), x, y, col);
      end
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_brush"}, 32'(brush), 0);
    chk({tag, "_hold_wx"}, 32'(wx), px + sz);
    chk({tag, "_hold_wy"}, 32'(wy), py + sz);
    @(negedge clk);
    chk({tag, "_after_done"}, 32'(done), 0);
    chk({tag, "_after_brush"}, 32'(brush), 0);
    chk({tag, "_after_busy"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset held with a request pending
    reset_n = 1'b0; req = 1'b1; clear_req = 1'b0;
    cx = 10'd3; cy = 10'd7; size = 2'd0; color = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_brush", 32'(brush), 0);
    chk("rst_wx", 32'(wx), 0);
    chk("rst_wy", 32'(wy), 0);
    chk("rst_color", 32'(newColor), 0);
    reset_n = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Single pixel, full brush, edge clipping, ignored mid-paint request
    paint(3, 7, 0, 5, 1'b0, "single");
    paint(2, 5, 3, 2, 1'b0, "full");
    paint(14, 14, 2, 6, 1'b0, "clip");
    paint(4, 1, 3, 3, 1'b1, "ignore");

    // Reset in the middle of a paint
    @(negedge clk);
    req = 1'b1; cx = 10'd2; cy = 10'd5; size = 2'd3; color = 3'd2;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_pre_brush", 32'(brush), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_brush", 32'(brush), 0);
    chk("midrst_wx", 32'(wx), 0);
    chk("midrst_wy", 32'(wy), 0);
    chk("midrst_color", 32'(newColor), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_after_busy", 32'(busy), 0);
      chk("midrst_after_done", 32'(done), 0);
      chk("midrst_after_brush", 32'(brush), 0);
    end

`ifdef BRUSH_CLEAR_EN
    // Clear and paint requested together: clear wins, paint is dropped
    @(negedge clk);
    clear_req = 1'b1; req = 1'b1; cx = 10'd9; cy = 10'd9; size = 2'd1; color = 3'd4;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 0) begin
        clear_req = 1'b0; req = 1'b0;
      end
      chk_px("clear", 1'b1, i % 16, i / 16, 0);
    end
    @(negedge clk);
    chk("clear_done", 32'(done), 1);
    chk("clear_done_busy", 32'(busy), 0);
    chk("clear_done_brush", 32'(brush), 0);
    @(negedge clk);
    chk("clear_dropped_brush", 32'(brush), 0);
    chk("clear_dropped_busy", 32'(busy), 0);
    chk("clear_dropped_done", 32'(done), 0);
`else
    // Without the clear feature, clear_req alone starts nothing
    @(negedge clk);
    clear_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("noclear_busy", 32'(busy), 0);
      chk("noclear_brush", 32'(brush), 0);
      chk("noclear_done", 32'(done), 0);
    end
    clear_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/brush_writer.md
# brush_writer

Write-side controller for the canvas pixel store. It accepts a paint request of cursor position, brush size and colour, then drives the store's write port (`brush`, `wx`, `wy`, `newColor`) one pixel per clock across a square footprint. Optionally it also sweeps the whole canvas to colour 0. It sits between the cursor/input logic and the pixel store; the VGA scan owns the store's read port.

## Interface
- `COORD_W`, 10: coordinate width, matching the store's `wx`/`wy`.
- `COLOR_W`, 3: colour code width.
- `CANVAS_W`, 16: canvas width in pixels; valid x is 0..CANVAS_W-1.
- `CANVAS_H`, 16: canvas height in pixels; valid y is 0..CANVAS_H-1.

Ports:
- `clk` input 1: single clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `req` input 1: paint request, sampled in IDLE.
- `cx`, `cy` input COORD_W: brush top-left corner.
- `size` input 2: brush edge length minus 1 (edge 1..4).
- `color` input COLOR_W: paint colour.
- `clear_req` input 1: canvas clear request, sampled in IDLE (CLEAR_EN only).
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when an operation completes.
- `brush` output 1: store write enable.
- `wx`, `wy` output COORD_W: write address.
- `newColor` output COLOR_W: write data.

## Operation
- States: IDLE, PAINT, CLEAR.
- IDLE:
  - `clear_req` has priority over `req`; `clear_req` goes to CLEAR.
  - Else `req` latches `cx`, `cy`, `size`, `color`, zeroes the offset counters `dx`, `dy` and goes to PAINT.
  - Requests presented while not in IDLE are ignored and not queued.
- PAINT:
  - Each cycle: `wx=cx+dx`, `wy=cy+dy`, `newColor=color`.
  - Order is row-major: `dx` increments first; at `dx==size` it wraps to 0 and `dy` increments.
  - `brush=1` only if `cx+dx < CANVAS_W` and `cy+dy < CANVAS_H`. Clipped pixels still take a cycle, with `brush=0`, but `wx`/`wy` still show the computed address.
  - Compute the sum at COORD_W+1 bits so carry-out counts as out of range.
  - After the `(size+1)^2`-th cycle, go to IDLE.
- CLEAR:
  - Sweep x 0..CANVAS_W-1 inner, y 0..CANVAS_H-1 outer, with `brush=1` and `newColor=0`.
  - That is CANVAS_W*CANVAS_H cycles, then IDLE.
- Latched inputs are not re-sampled mid-operation. Input changes during PAINT have no effect.

## Timing
- All outputs are registered.
- Reset values: `busy=0`, `done=0`, `brush=0`, `wx=0`, `wy=0`, `newColor=0`, state IDLE.
- `req` accepted on edge N: first write is presented in cycle N+1, and `busy=1` from N+1.
- Last write in cycle M: in cycle M+1, `busy=0`, `brush=0` and `done=1` for exactly one cycle.
- A new request may be sampled on the edge that ends cycle M+1, i.e. the `done` cycle.
- Outside PAINT and CLEAR, `brush=0` and `wx`/`wy`/`newColor` hold their last values.
- PAINT lasts `(size+1)^2` cycles, from 1 to 16.
- CLEAR lasts CANVAS_W*CANVAS_H cycles (256 at defaults).
- Asserting `reset_n` low mid-operation forces reset values immediately. No partial `done` is produced, and the aborted operation is not resumed.
- The store registers the write on the edge following a `brush=1` cycle.

## Configuration
- `BRUSH_CLEAR_EN` defined: the CLEAR state and `clear_req` are functional.
- Not defined:
  - The CLEAR state is absent.
  - The `clear_req` port remains but is ignored.
  - `req` is the only request source.

## Test plan
- Reset: hold `reset_n` low with `req=1` -> all outputs 0, no `brush`. Release -> IDLE, the next `req` is accepted.
- Single pixel: `req` with `cx=3`, `cy=7`, `size=0`, `color=5` -> one cycle `brush=1`, `wx=3`, `wy=7`, `newColor=5`. Next cycle `done=1`, `busy=0`.
- Full brush: `cx=2`, `cy=5`, `size=3`, `color=2` -> 16 consecutive writes (2,5),(3,5),(4,5),(5,5),(2,6)...(5,8), then `done`.
- Edge clipping: `cx=14`, `cy=14`, `size=2` -> 9 cycles; `brush=1` only at (14,14),(15,14),(14,15),(15,15).
- Busy ignore: second `req` with `cx=0` asserted mid-paint -> no extra writes; `done` pulses once.
- Clear (`BRUSH_CLEAR_EN` defined): `clear_req` and `req` together -> CLEAR wins; 256 writes of colour 0 from (0,0) to (15,15); then `done`; the `req` is dropped.
